io_out_compressor: RTL

Output path of the IO subsystem. Reads result words (X vector) from the accelerator RAM and run-length encodes each word into 8-bit tokens, using the same token format the input-side decompressors consume. It packs four tokens per bus word and hands the packed words to the CPU over a valid/ready bus, flagging the final word with end-of-block.

---
 rtl/io_pkg.sv | 35 +++
 rtl/io_token_packer.sv | 72 +++++++
 rtl/io_out_compressor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the IO output path: token layout, pack geometry and
// the compressor state encoding.
package io_pkg;

    localparam int TOKEN_W        = 8;
    localparam int TOK_VAL_BIT    = 6;
    localparam int TOK_LEN_W      = 6;
    localparam int SLOTS          = 4;
    localparam int BUS_W          = SLOTS * TOKEN_W;
    localparam int X_BASE_DEFAULT = 20;

    localparam logic [TOKEN_W-1:0] NULL_TOKEN = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SCAN,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef logic [SLOTS-1:0][TOKEN_W-1:0] pack_t;

    function automatic logic [TOKEN_W-1:0] make_token(input logic value,
                                                      input logic [TOK_LEN_W-1:0] len);
        logic [TOKEN_W-1:0] tok;
        tok                  = NULL_TOKEN;
        tok[TOK_VAL_BIT]     = value;
        tok[TOK_LEN_W-1:0]   = len;
        return tok;
    endfunction

endpackage

// File: rtl/io_token_packer.sv
// Collects RLE tokens four to a bus word and presents them on a valid/ready
// bus; back-pressure is reported upstream through stall.
module io_token_packer
    import io_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             emit,
    input  logic [TOKEN_W-1:0] token,
    input  logic             last,
    input  logic             flush,
    input  logic             ready,
    output logic [BUS_W-1:0] data_out,
    output logic             valid,
    output logic             eob,
    output logic             stall
);

    pack_t      pack, pack_n;
    logic [1:0] slot, slot_n;
    logic       valid_n, eob_n;
    logic       handshake;

    assign handshake = valid && ready;
    assign stall     = valid && !ready;
    assign data_out  = pack;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        pack_n  = handshake ? '0 : pack;
        slot_n  = slot;
        valid_n = handshake ? 1'b0 : valid;
        eob_n   = handshake ? 1'b0 : eob;

        if (emit && !stall) begin
            // A full pack is always left at slot 0, so a write during a
            // handshake lands in the freshly cleared word.
            pack_n[slot] = token;
            slot_n       = slot + 2'd1;
            if (slot == 2'd3) begin
                valid_n = 1'b1;
                eob_n   = last;
            end
        end else if (flush && !valid && slot != 2'd0) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (k >= int'(slot)) begin
                    pack_n[k] = NULL_TOKEN;
                end
            end
            slot_n  = 2'd0;
            valid_n = 1'b1;
            eob_n   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pack  <= '0;
            slot  <= 2'd0;
            valid <= 1'b0;
            eob   <= 1'b0;
        end else begin
            pack  <= pack_n;
            slot  <= slot_n;
            valid <= valid_n;
            eob   <= eob_n;
        end
    end

endmodule

// File: rtl/io_out_compressor.sv
// Output path: fetches result words from RAM, run-length encodes each word
// LSB first and streams the packed tokens to the CPU.
module io_out_compressor
    import io_pkg::*;
#(
    parameter int N      = 32,
    parameter int ADDR_W = 20,
    parameter int X_BASE = X_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] count,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [N-1:0]      mem_rdata,
    output logic [N-1:0]      data_out,
    output logic              valid,
    input  logic              ready,
    output logic              eob,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = $clog2(N);

    state_t                 state, state_n;
    logic [ADDR_W-1:0]      count_q, index_q;
    logic [N-1:0]           shreg;
    logic [BIT_W-1:0]       bit_idx;
    logic                   run_val;
    logic [TOK_LEN_W-1:0]   run_len;
    logic                   busy_q, done_q;

    logic                   emit, last, flush, stall;
    logic [TOKEN_W-1:0]     token;
    logic                   cur_bit, last_word, last_bit;

    assign cur_bit   = shreg[0];
    assign last_word = (index_q == count_q - ADDR_W'(1));
    assign last_bit  = (bit_idx == BIT_W'(N - 1));
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (start) state_n = (count != '0) ? ST_FETCH : ST_DONE;
            ST_FETCH: state_n = ST_WAIT;
            ST_WAIT:  state_n = ST_SCAN;
            ST_SCAN:  if (!stall && last_bit) state_n = ST_FLUSH;
            ST_FLUSH: if (!stall) state_n = last_word ? ST_DRAIN : ST_FETCH;
            ST_DRAIN: if (valid && ready && eob) state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = '0;
        emit     = 1'b0;
        last     = 1'b0;
        flush    = 1'b0;
        token    = make_token(run_val, run_len);
        case (state)
            ST_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = ADDR_W'(X_BASE) + index_q;
            end
            ST_SCAN:  emit  = (bit_idx != '0) && (cur_bit != run_val);
            ST_FLUSH: begin
                emit = 1'b1;
                last = last_word;
            end
            ST_DRAIN: flush = 1'b1;
            default:  ;
        endcase
    end

    // Datapath registers: word index, shift register and the current run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            index_q <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            run_val <= 1'b0;
            run_len <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        count_q <= count;
                        index_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    shreg   <= mem_rdata;
                    bit_idx <= '0;
                end
                ST_SCAN: begin
                    if (!stall) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + BIT_W'(1);
                        if (bit_idx == '0 || cur_bit != run_val) begin
                            run_val <= cur_bit;
                            run_len <= TOK_LEN_W'(1);
                        end else begin
                            run_len <= run_len + TOK_LEN_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!stall && !last_word) index_q <= index_q + ADDR_W'(1);
                end
                ST_DONE:  busy_q <= 1'b0;
                default:  ;
            endcase
        end
    end

    io_token_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .emit     (emit),
        .token    (token),
        .last     (last),
        .flush    (flush),
        .ready    (ready),
        .data_out (data_out),
        .valid    (valid),
        .eob      (eob),
        .stall    (stall)
    );

endmodule
